stopwatch_counter: RTL and testbench

//  Time-base and BCD digit chain driven by the stopwatch control FSM.

---
 rtl/stopwatch_pkg.sv | 27 ++
 rtl/bcd_digit.sv | 40 ++++
 rtl/stopwatch_counter.sv | 84 ++++++++
 tb/tb_stopwatch_counter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch: BCD digit widths/moduli and the
// control-FSM state encodings used by the controller and the counter.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] TENTHS_MAX   = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] MIN_ONES_MAX = 4'd9;

    typedef logic [1:0] sw_state_t;
    localparam sw_state_t ST_IDLE     = 2'd0;
    localparam sw_state_t ST_COUNTING = 2'd1;
    localparam sw_state_t ST_PAUSED   = 2'd2;

    // Anything at or above the modulus counts as terminal, so a corrupted
    // digit self-heals to 0 on its next increment.
    function automatic logic [DIGIT_W-1:0] digit_next(input logic [DIGIT_W-1:0] q,
                                                      input logic [DIGIT_W-1:0] max);
        if (q >= max) begin
            return '0;
        end
        return q + DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch chain: counts 0..MAX, carries out
// combinationally when incremented at its terminal value.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    assign carry = inc & (q_q >= MAX);

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = digit_next(q_q, MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time base: divides clk to 0.1 s steps and advances an M:SS.t
// BCD digit chain, with registered tick/wrap strobes aligned to the change.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int DIV     = 10_000_000,
    parameter int PRESC_W = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_regs,
    input  logic       count_enabled,
    output logic [3:0] tenths,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic       tick,
    output logic       wrap
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               step;
    logic               tick_q;
    logic               wrap_q;
    logic               carry_t;
    logic               carry_so;
    logic               carry_st;
    logic               carry_mo;

    // init_regs overrides enable, so an illegal init+enable still clears.
    always_comb begin
        presc_d = presc_q;
        step    = 1'b0;
        if (init_regs) begin
            presc_d = '0;
        end else if (count_enabled) begin
            if (presc_q >= PRESC_LAST) begin
                presc_d = '0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= step;
            wrap_q  <= carry_mo;
        end
    end

    bcd_digit #(.MAX(TENTHS_MAX)) u_tenths (
        .clk(clk), .reset(reset), .clr(init_regs), .inc(step),
        .q(tenths), .carry(carry_t)
    );

    bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .reset(reset), .clr(init_regs), .inc(carry_t),
        .q(sec_ones), .carry(carry_so)
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .reset(reset), .clr(init_regs), .inc(carry_so),
        .q(sec_tens), .carry(carry_st)
    );

    bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .reset(reset), .clr(init_regs), .inc(carry_st),
        .q(min_ones), .carry(carry_mo)
    );

    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter with DIV=4: vector table, hand-written corner
// sequences and random stimulus, all checked against a tenths-count model.
module tb_stopwatch_counter;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       init_regs = 1'b0;
    logic       count_enabled = 1'b0;
    logic [3:0] tenths;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic       tick;
    logic       wrap;

    stopwatch_counter #(.DIV(DIV), .PRESC_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .init_regs(init_regs),
        .count_enabled(count_enabled),
        .tenths(tenths),
        .sec_ones(sec_ones),
        .sec_tens(sec_tens),
        .min_ones(min_ones),
        .tick(tick),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: elapsed time as a plain count of tenths (mod 10 minutes).
    int m_t     = 0;
    int m_pre   = 0;
    int m_tick  = 0;
    int m_wrap  = 0;

    typedef struct {
        bit r;
        bit i;
        bit e;
        int exp_disp;
        int exp_tick;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int dut_disp();
        return int'(min_ones) * 1000 + int'(sec_tens) * 100 + int'(sec_ones) * 10 + int'(tenths);
    endfunction

    function automatic int model_disp();
        return (m_t / 600) * 1000 + ((m_t / 100) % 6) * 100 + ((m_t / 10) % 10) * 10 + (m_t % 10);
    endfunction

    task automatic cyc(input bit r, input bit i, input bit e);
        @(negedge clk);
        reset         = r;
        init_regs     = i;
        count_enabled = e;
        @(posedge clk);
        m_tick = 0;
        m_wrap = 0;
        if (r || i) begin
            m_t   = 0;
            m_pre = 0;
        end else if (e) begin
            m_pre++;
            if (m_pre == DIV) begin
                m_pre  = 0;
                m_t    = (m_t + 1) % 6000;
                m_tick = 1;
                m_wrap = (m_t == 0) ? 1 : 0;
            end
        end
        #1;
        check("model digits", dut_disp(), model_disp());
        check("model tick", int'(tick), m_tick);
        check("model wrap", int'(wrap), m_wrap);
    endtask

    task automatic run_steps(input int n);
        for (int k = 0; k < n * DIV; k++) begin
            cyc(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic clear_mid_count(input bit use_reset, input string tag);
        cyc(1'b0, 1'b1, 1'b0);
        run_steps(32);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        check({tag, " pre 0:03.2"}, dut_disp(), 32);
        cyc(use_reset, ~use_reset, 1'b1);
        check({tag, " cleared digits"}, dut_disp(), 0);
        check({tag, " cleared tick"}, int'(tick), 0);
        for (int k = 0; k < DIV - 1; k++) begin
            cyc(1'b0, 1'b0, 1'b1);
            check({tag, " no early step"}, dut_disp(), 0);
        end
        cyc(1'b0, 1'b0, 1'b1);
        check({tag, " first step"}, dut_disp(), 1);
        check({tag, " first tick"}, int'(tick), 1);
    endtask

    initial begin
        // Reset with init and enable also driven, then counting and pause.
        vecs.push_back('{1, 1, 1, 0, 0});
        vecs.push_back('{1, 1, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 1});
        vecs.push_back('{0, 0, 1, 1, 0});
        vecs.push_back('{0, 0, 1, 1, 0});
        vecs.push_back('{0, 0, 1, 1, 0});
        vecs.push_back('{0, 0, 1, 2, 1});
        vecs.push_back('{0, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 0});
        for (int k = 0; k < 10; k++) begin
            vecs.push_back('{0, 0, 0, 0, 0});
        end
        vecs.push_back('{0, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 1});
        vecs.push_back('{0, 0, 1, 1, 0});

        for (int v = 0; v < vecs.size(); v++) begin
            cyc(vecs[v].r, vecs[v].i, vecs[v].e);
            check($sformatf("vec%0d digits", v), dut_disp(), vecs[v].exp_disp);
            check($sformatf("vec%0d tick", v), int'(tick), vecs[v].exp_tick);
            check($sformatf("vec%0d wrap", v), int'(wrap), 0);
        end

        // Carry chain through seconds and into minutes.
        cyc(1'b0, 1'b1, 1'b0);
        run_steps(99);
        check("carry 0:09.9", dut_disp(), 99);
        run_steps(1);
        check("carry 0:10.0", dut_disp(), 100);
        run_steps(499);
        check("carry 0:59.9", dut_disp(), 599);
        run_steps(1);
        check("carry 1:00.0", dut_disp(), 1000);

        // Full wrap 9:59.9 -> 0:00.0.
        cyc(1'b0, 1'b1, 1'b0);
        run_steps(5999);
        check("wrap 9:59.9", dut_disp(), 9599);
        check("wrap low before", int'(wrap), 0);
        run_steps(1);
        check("wrap digits", dut_disp(), 0);
        check("wrap pulse", int'(wrap), 1);
        check("wrap tick", int'(tick), 1);
        cyc(1'b0, 1'b0, 1'b1);
        check("wrap one cycle", int'(wrap), 0);
        check("tick one cycle", int'(tick), 0);

        clear_mid_count(1'b0, "init");
        clear_mid_count(1'b1, "reset");

        // Random control traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(199) == 0), ($urandom_range(99) == 0), ($urandom_range(3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
